// File: rtl/cla_nibble_serial_adder_if.sv
// Handshake and data bundle for the nibble-serial CLA adder.
// The master drives operands and out_ready; the slave (the adder) drives results.
interface cla_nibble_serial_adder_if #(
  parameter int unsigned WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             overflow;

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, overflow
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, overflow
  );
endinterface

// File: rtl/cla_nibble_serial_adder.sv
// WIDTH-bit adder built from one 4-bit carry-lookahead cell, one nibble per cycle, LSB first.
// Results are held in DONE until the consumer takes them; a new add may be accepted on that edge.
module cla_nibble_serial_adder #(
  parameter int unsigned WIDTH = 16
) (
  input logic                      clk,
  input logic                      rst_n,
  cla_nibble_serial_adder_if.slave bus
);
  localparam int unsigned N    = WIDTH / 4;
  localparam int unsigned CntW = $clog2(N);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic             carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d;
  logic             out_valid_q, out_valid_d;
  logic [CntW-1:0]  count_q, count_d;

  logic [3:0] nib_a, nib_b, nib_s, p, g;
  logic [4:0] c;
  logic       accept;

  // Shared 4-bit carry-lookahead cell fed by the current nibble and the registered carry.
  always_comb begin
    nib_a = a_q[{count_q, 2'b00} +: 4];
    nib_b = b_q[{count_q, 2'b00} +: 4];
    p     = nib_a ^ nib_b;
    g     = nib_a & nib_b;
    c[0]  = carry_q;
    c[1]  = g[0] | (p[0] & c[0]);
    c[2]  = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    c[3]  = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
    c[4]  = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
          | (p[3] & p[2] & p[1] & p[0] & c[0]);
    nib_s = p ^ c[3:0];
  end

  // Held low during reset; in DONE the consumer's ready opens the input for back-to-back adds.
  assign bus.in_ready = rst_n & ((state_q == StIdle) | ((state_q == StDone) & bus.out_ready));
  assign accept       = bus.in_valid & bus.in_ready;

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    sum_d       = sum_q;
    carry_d     = carry_q;
    count_d     = count_q;
    cout_d      = cout_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          a_d     = bus.a;
          b_d     = bus.b;
          carry_d = bus.cin;
          count_d = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        sum_d[{count_q, 2'b00} +: 4] = nib_s;
        carry_d                      = c[4];
        count_d                      = count_q + CntW'(1);
        if (count_q == CntW'(N - 1)) begin
          cout_d      = c[4];
          ovf_d       = a_q[WIDTH-1] ^ b_q[WIDTH-1] ^ nib_s[3] ^ c[4];
          out_valid_d = 1'b1;
          state_d     = StDone;
        end
      end
      StDone: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          if (accept) begin
            a_d     = bus.a;
            b_d     = bus.b;
            carry_d = bus.cin;
            count_d = '0;
            state_d = StRun;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      carry_q     <= 1'b0;
      count_q     <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sum_q       <= sum_d;
      carry_q     <= carry_d;
      count_q     <= count_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.overflow  = ovf_q;
endmodule
